// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FSM state encoding, IF/ID register layout and bubble encoding.
package if_fetch_pkg;

    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2,
        IF_DROP = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational lookup, single fill port; only instantiated when IF_ICACHE_EN is defined.
module if_fetch_icache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_addr,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        fill_en,
    input  logic [31:0] fill_addr,
    input  logic [31:0] fill_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid_q;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [TAG_W-1:0] fill_tag;

    assign lookup_idx = lookup_addr[IDX_W+1:2];
    assign lookup_tag = lookup_addr[31:IDX_W+2];
    assign fill_idx   = fill_addr[IDX_W+1:2];
    assign fill_tag   = fill_addr[31:IDX_W+2];

    assign hit      = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign hit_data = data_mem[lookup_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; the valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_data;
        end
    end

    logic unused_byte_bits;
    assign unused_byte_bits = ^{lookup_addr[1:0], fill_addr[1:0]};

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: req/ack fetch FSM, stall request and IF/ID register.
// Define IF_ICACHE_EN to add the direct-mapped I-cache in front of memory.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int          ICACHE_LINES = 64,
    parameter logic [31:0] NOP_INST     = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    if_state_e   state, state_next;
    logic [31:0] addr_q;
    logic [31:0] hold_q;
    ifid_t       ifid_q, ifid_next;

    logic        hold_ifid;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        deliver;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_data;
    logic        capture;
    logic [31:0] capture_data;

    assign hold_ifid = stall[1];

`ifdef IF_ICACHE_EN
    logic fill_en;
    // A late ack in DROP still carries the right word for addr_q, so it may fill.
    assign fill_en = mem_ack_i && !flush_i && (state == IF_REQ || state == IF_DROP);

    if_fetch_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk        (clk),
        .rst        (rst),
        .lookup_addr(pc_i),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .fill_en    (fill_en),
        .fill_addr  (addr_q),
        .fill_data  (mem_data_i)
    );
`else
    localparam int unused_icache_lines = ICACHE_LINES;
    assign cache_hit  = 1'b0;
    assign cache_data = ZERO_WORD;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IF_IDLE: begin
                if (!cache_hit)                  state_next = IF_REQ;
                else if (!flush_i && hold_ifid)  state_next = IF_HOLD;
            end
            IF_REQ: begin
                if (mem_ack_i)                   state_next = (flush_i || !hold_ifid) ? IF_IDLE : IF_HOLD;
                else if (flush_i)                state_next = IF_DROP;
            end
            IF_HOLD: begin
                if (flush_i || !hold_ifid)       state_next = IF_IDLE;
            end
            IF_DROP: begin
                if (mem_ack_i)                   state_next = IF_IDLE;
            end
            default:                             state_next = IF_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o  = (state == IF_REQ) || (state == IF_DROP);
        stallreq_o = 1'b1;
        unique case (state)
            IF_IDLE: stallreq_o = !cache_hit;
            IF_REQ:  stallreq_o = !(mem_ack_i && !flush_i);
            IF_HOLD: stallreq_o = 1'b0;
            default: stallreq_o = 1'b1;
        endcase
    end

    // Which word (if any) reaches IF/ID or the hold buffer this cycle.
    always_comb begin
        deliver      = 1'b0;
        deliver_pc   = addr_q;
        deliver_data = hold_q;
        capture      = 1'b0;
        capture_data = mem_data_i;
        unique case (state)
            IF_IDLE: if (cache_hit && !flush_i) begin
                capture      = hold_ifid;
                capture_data = cache_data;
                deliver      = !hold_ifid;
                deliver_pc   = pc_i;
                deliver_data = cache_data;
            end
            IF_REQ: if (mem_ack_i && !flush_i) begin
                capture      = hold_ifid;
                deliver      = !hold_ifid;
                deliver_data = mem_data_i;
            end
            IF_HOLD: deliver = !flush_i && !hold_ifid;
            default: ;
        endcase
    end

    always_comb begin
        ifid_next = '{pc: ifid_q.pc, inst: NOP_INST, valid: 1'b0};
        if (flush_i) begin
            ifid_next = '{pc: ifid_q.pc, inst: NOP_INST, valid: 1'b0};
        end else if (deliver) begin
            ifid_next = '{pc: deliver_pc, inst: deliver_data, valid: 1'b1};
        end else if (hold_ifid) begin
            ifid_next = ifid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= ZERO_WORD;
            hold_q <= ZERO_WORD;
            ifid_q <= '{pc: ZERO_WORD, inst: NOP_INST, valid: 1'b0};
        end else begin
            if (state == IF_IDLE) addr_q <= pc_i;
            if (capture)          hold_q <= capture_data;
            ifid_q <= ifid_next;
        end
    end

    assign mem_addr_o = addr_q;
    assign id_pc_o    = ifid_q.pc;
    assign id_inst_o  = ifid_q.inst;
    assign id_valid_o = ifid_q.valid;

    logic unused_stall;
    assign unused_stall = ^{stall[5:2], stall[0]};

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch; the cache scenario runs when IF_ICACHE_EN is defined.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic [5:0]  stall;
    logic        flush_i;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    int checks = 0;
    int errors = 0;

    if_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .stall     (stall),
        .flush_i   (flush_i),
        .stallreq_o(stallreq_o),
        .mem_req_o (mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i (mem_ack_i),
        .mem_data_i(mem_data_i),
        .id_pc_o   (id_pc_o),
        .id_inst_o (id_inst_o),
        .id_valid_o(id_valid_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_i = 32'h0; stall = 6'b0; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_data_i = 32'h0;
        step(); step();
        rst = 1'b0;
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", id_pc_o, 32'h0); end
        checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL reset_inst got %h want %h", id_inst_o, NOP); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", id_valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req_o); end
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL reset_stallreq got %b want 1", stallreq_o); end
    endtask

    task automatic test_basic_fetch();
        pc_i = 32'h0;
        step();
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t1_req got %b want 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL t1_addr got %h want %h", mem_addr_o, 32'h0); end
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL t1_stall_wait0 got %b want 1", stallreq_o); end
        step();
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL t1_stall_wait1 got %b want 1", stallreq_o); end
        step();
        mem_ack_i = 1'b1; mem_data_i = 32'h0050_0093;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL t1_stall_ack got %b want 0", stallreq_o); end
        step();
        mem_ack_i = 1'b0; pc_i = 32'h4;
        checks++; if (id_inst_o !== 32'h0050_0093) begin errors++; $display("FAIL t1_inst got %h want %h", id_inst_o, 32'h0050_0093); end
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL t1_pc got %h want %h", id_pc_o, 32'h0); end
        checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL t1_valid got %b want 1", id_valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t1_idle_req got %b want 0", mem_req_o); end
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL t1_idle_stall got %b want 1", stallreq_o); end
    endtask

    task automatic test_stall_hold();
        step();
        stall = 6'b000010; mem_ack_i = 1'b1; mem_data_i = 32'h00A0_0113;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL t2_stall_ack got %b want 0", stallreq_o); end
        step();
        mem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_hold_req[%0d] got %b want 0", i, mem_req_o); end
            checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL t2_hold_valid[%0d] got %b want 0", i, id_valid_o); end
            checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL t2_hold_inst[%0d] got %h want %h", i, id_inst_o, NOP); end
            checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL t2_hold_stallreq[%0d] got %b want 0", i, stallreq_o); end
            if (i < 2) step();
        end
        stall = 6'b0;
        step();
        checks++; if (id_inst_o !== 32'h00A0_0113) begin errors++; $display("FAIL t2_inst got %h want %h", id_inst_o, 32'h00A0_0113); end
        checks++; if (id_pc_o !== 32'h4) begin errors++; $display("FAIL t2_pc got %h want %h", id_pc_o, 32'h4); end
        checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL t2_valid got %b want 1", id_valid_o); end
    endtask

    task automatic test_flush_drop();
        pc_i = 32'h8;
        step();
        checks++; if (mem_addr_o !== 32'h8) begin errors++; $display("FAIL t3_addr got %h want %h", mem_addr_o, 32'h8); end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; pc_i = 32'h20;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t3_drop_req got %b want 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h8) begin errors++; $display("FAIL t3_drop_addr got %h want %h", mem_addr_o, 32'h8); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL t3_flush_valid got %b want 0", id_valid_o); end
        checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL t3_flush_inst got %h want %h", id_inst_o, NOP); end
        step(); step();
        mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL t3_drop_stallreq got %b want 1", stallreq_o); end
        step();
        mem_ack_i = 1'b0;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL t3_discard_valid got %b want 0", id_valid_o); end
        checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL t3_discard_inst got %h want %h", id_inst_o, NOP); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t3_idle_req got %b want 0", mem_req_o); end
        step();
        checks++; if (mem_addr_o !== 32'h20) begin errors++; $display("FAIL t3_new_addr got %h want %h", mem_addr_o, 32'h20); end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t3_new_req got %b want 1", mem_req_o); end
    endtask

    task automatic test_flush_with_ack();
        mem_ack_i = 1'b1; flush_i = 1'b1; mem_data_i = 32'h1234_5678;
        #1;
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL t4_stallreq got %b want 1", stallreq_o); end
        step();
        mem_ack_i = 1'b0; flush_i = 1'b0;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL t4_valid got %b want 0", id_valid_o); end
        checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL t4_inst got %h want %h", id_inst_o, NOP); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t4_idle_req got %b want 0", mem_req_o); end
    endtask

    task automatic test_reset_mid_fetch();
        pc_i = 32'h40;
        step();
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t5_req got %b want 1", mem_req_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t5_rst_req got %b want 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL t5_rst_addr got %h want %h", mem_addr_o, 32'h0); end
        checks++; if (id_pc_o !== 32'h0) begin errors++; $display("FAIL t5_rst_pc got %h want %h", id_pc_o, 32'h0); end
        checks++; if (id_inst_o !== NOP) begin errors++; $display("FAIL t5_rst_inst got %h want %h", id_inst_o, NOP); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("FAIL t5_rst_valid got %b want 0", id_valid_o); end
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL t5_rst_stallreq got %b want 1", stallreq_o); end
    endtask

`ifdef IF_ICACHE_EN
    task automatic test_icache_loop();
        logic [31:0] words [4];
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193; words[3] = 32'h0040_0213;
        for (int i = 0; i < 4; i++) begin
            pc_i = 32'h100 + 32'(i * 4);
            step();
            checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t6_miss_req[%0d] got %b want 1", i, mem_req_o); end
            mem_ack_i = 1'b1; mem_data_i = words[i];
            step();
            mem_ack_i = 1'b0;
            checks++; if (id_inst_o !== words[i]) begin errors++; $display("FAIL t6_fill_inst[%0d] got %h want %h", i, id_inst_o, words[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            pc_i = 32'h100 + 32'(i * 4);
            #1;
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t6_hit_req[%0d] got %b want 0", i, mem_req_o); end
            checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL t6_hit_stallreq[%0d] got %b want 0", i, stallreq_o); end
            step();
            checks++; if (id_inst_o !== words[i]) begin errors++; $display("FAIL t6_hit_inst[%0d] got %h want %h", i, id_inst_o, words[i]); end
            checks++; if (id_pc_o !== 32'h100 + 32'(i * 4)) begin errors++; $display("FAIL t6_hit_pc[%0d] got %h want %h", i, id_pc_o, 32'h100 + 32'(i * 4)); end
            checks++; if (id_valid_o !== 1'b1) begin errors++; $display("FAIL t6_hit_valid[%0d] got %b want 1", i, id_valid_o); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_flush_drop();
        test_flush_with_ack();
        test_reset_mid_fetch();
`ifdef IF_ICACHE_EN
        test_icache_loop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
